// File: rtl/tmds_pll_ctrl.sv
// rtl/tmds_pll_ctrl.sv - rPLL divider preset, reset sequencing and lock qualification controller
module tmds_pll_ctrl #(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    parameter int DEFAULT_MODE = 0,
    parameter logic [6*NUM_MODES-1:0] IDSEL_TABLE  = {6'd60, 6'd62, 6'd61, 6'd63},
    parameter logic [6*NUM_MODES-1:0] FBDSEL_TABLE = {6'd10, 6'd20, 6'd30, 6'd40},
    parameter logic [6*NUM_MODES-1:0] ODSEL_TABLE  = {6'd56, 6'd60, 6'd62, 6'd63},
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              mode_req_valid,
    output logic              mode_req_ready,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic [MODE_W-1:0] mode_cur,
    output logic              locked,
    output logic              pix_rst_n,
    output logic              fail,
    output logic              req_err,
    output logic [7:0]        lock_loss_cnt
);

    // One shared counter serves the reset hold, lock timeout and stability windows.
    localparam int CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT)
                           ? ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES)
                           : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [MODE_W:0]    MODE_LIMIT   = (MODE_W + 1)'(NUM_MODES);
    localparam logic [MODE_W-1:0]  MODE_RST     = MODE_W'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_LOCKED    = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [7:0]           loss_q, loss_d;
    logic                 req_err_d;
    logic                 accept, req_in_range;
    logic                 lock_meta_q, lock_sync_q;
    logic                 pll_reset_q, locked_q, pix_rst_n_q, fail_q, ready_q, req_err_q;
    logic [5:0]           idsel_q, fbdsel_q, odsel_q;

    // Extract a 6-bit preset from a packed table with constant part-selects only.
    function automatic logic [5:0] entry6(input logic [6*NUM_MODES-1:0] tbl,
                                          input logic [MODE_W-1:0] idx);
        logic [5:0] e;
        e = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (idx == MODE_W'(k)) e = tbl[6*k +: 6];
        end
        return e;
    endfunction

    assign accept       = mode_req_valid & ready_q;
    assign req_in_range = {1'b0, mode_req} < MODE_LIMIT;
    assign retry_inc    = retry_q + 1'b1;

    // Next-state logic; an accepted request overrides whatever the state machine decided.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        mode_d    = mode_q;
        loss_d    = loss_q;
        req_err_d = 1'b0;
        case (state_q)
            S_RST: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc < RETRY_LIMIT) ? S_RST : S_FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_sync_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOCKED: begin
                if (!lock_sync_q) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 1'b1;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            if (req_in_range) begin
                state_d = S_RST;
                cnt_d   = '0;
                retry_d = '0;
                mode_d  = mode_req;
            end else begin
                req_err_d = 1'b1;
            end
        end
    end

    // State, lock synchroniser and registered outputs derived from the next state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            mode_q      <= MODE_RST;
            loss_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            pix_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
            ready_q     <= 1'b0;
            req_err_q   <= 1'b0;
            idsel_q     <= entry6(IDSEL_TABLE, MODE_RST);
            fbdsel_q    <= entry6(FBDSEL_TABLE, MODE_RST);
            odsel_q     <= entry6(ODSEL_TABLE, MODE_RST);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            mode_q      <= mode_d;
            loss_q      <= loss_d;
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
            pll_reset_q <= (state_d == S_RST) || (state_d == S_FAIL);
            locked_q    <= (state_d == S_LOCKED);
            pix_rst_n_q <= (state_d == S_LOCKED);
            fail_q      <= (state_d == S_FAIL);
            ready_q     <= (state_d == S_LOCKED) || (state_d == S_FAIL);
            req_err_q   <= req_err_d;
            // mode_d only moves on entry to RST, so the divider pins follow suit.
            idsel_q     <= entry6(IDSEL_TABLE, mode_d);
            fbdsel_q    <= entry6(FBDSEL_TABLE, mode_d);
            odsel_q     <= entry6(ODSEL_TABLE, mode_d);
        end
    end

    assign mode_req_ready = ready_q;
    assign pll_reset      = pll_reset_q;
    assign pll_idsel      = idsel_q;
    assign pll_fbdsel     = fbdsel_q;
    assign pll_odsel      = odsel_q;
    assign mode_cur       = mode_q;
    assign locked         = locked_q;
    assign pix_rst_n      = pix_rst_n_q;
    assign fail           = fail_q;
    assign req_err        = req_err_q;
    assign lock_loss_cnt  = loss_q;

endmodule

// File: tb/tb_tmds_pll_ctrl.sv
// tb/tb_tmds_pll_ctrl.sv - self-checking bench for tmds_pll_ctrl
`timescale 1ns/1ps
module tb_tmds_pll_ctrl;

    localparam logic [17:0] ID_T = {6'd5, 6'd3, 6'd1};
    localparam logic [17:0] FB_T = {6'd20, 6'd12, 6'd10};
    localparam logic [17:0] OD_T = {6'd8, 6'd4, 6'd2};

    int exp_id [3] = '{1, 3, 5};
    int exp_fb [3] = '{10, 12, 20};
    int exp_od [3] = '{2, 4, 8};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [1:0] mode_cur;
    logic       locked, pix_rst_n, fail, req_err;
    logic [7:0] lock_loss_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lock_delay = 20;
    int   since = 0;
    logic model_lock = 1'b0;
    logic force_low = 1'b0;

    tmds_pll_ctrl #(
        .NUM_MODES(3), .DEFAULT_MODE(0),
        .IDSEL_TABLE(ID_T), .FBDSEL_TABLE(FB_T), .ODSEL_TABLE(OD_T),
        .RESET_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRY(2)
    ) dut (
        .clkin(clk), .rst_n(rst_n),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .mode_cur(mode_cur), .locked(locked), .pix_rst_n(pix_rst_n), .fail(fail),
        .req_err(req_err), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: LOCK rises lock_delay cycles after RESET falls, drops while RESET is high.
    always @(posedge clk) begin
        if (pll_reset) begin
            since      <= 0;
            model_lock <= 1'b0;
        end else begin
            since <= since + 1;
            if (since + 1 >= lock_delay) model_lock <= 1'b1;
        end
    end

    assign pll_lock = model_lock & ~force_low;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // which: 0 locked high, 1 pll_reset low, 2 fail high, 3 pll_reset high; at=-1 on timeout
    task automatic wait_until(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if ((which == 0 && locked) || (which == 1 && !pll_reset) ||
                (which == 2 && fail) || (which == 3 && pll_reset)) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic do_req(input int m, output int t);
        mode_req       = 2'(m);
        mode_req_valid = 1'b1;
        step(1);
        t              = cyc;
        mode_req_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pll_reset"}, int'(pll_reset), 1);
        check({tag, "_idsel"}, int'(pll_idsel), exp_id[0]);
        check({tag, "_fbdsel"}, int'(pll_fbdsel), exp_fb[0]);
        check({tag, "_odsel"}, int'(pll_odsel), exp_od[0]);
        check({tag, "_mode_cur"}, int'(mode_cur), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_pix_rst_n"}, int'(pix_rst_n), 0);
        check({tag, "_fail"}, int'(fail), 0);
        check({tag, "_req_err"}, int'(req_err), 0);
        check({tag, "_ready"}, int'(mode_req_ready), 0);
        check({tag, "_loss"}, int'(lock_loss_cnt), 0);
    endtask

    typedef struct {
        int mode;
        int exp_mode;
        int exp_idsel;
        int exp_fbdsel;
        int exp_odsel;
        int exp_err;
        int exp_locked;
    } req_vec_t;

    req_vec_t vecs[6];

    initial begin
        int t, at, x, p0, e0, m, d, r, exp_mode, exp_fail, lpt;

        vecs[0] = '{2, 2, 5, 20, 8, 0, 0};
        vecs[1] = '{3, 2, 5, 20, 8, 1, 1};
        vecs[2] = '{0, 0, 1, 10, 2, 0, 0};
        vecs[3] = '{1, 1, 3, 12, 4, 0, 0};
        vecs[4] = '{1, 1, 3, 12, 4, 0, 0};
        vecs[5] = '{3, 1, 3, 12, 4, 1, 1};

        rst_n = 1'b0;
        mode_req = 2'd0;
        mode_req_valid = 1'b0;
        step(3);
        check_reset("por");

        // Power-up sequence with lock 20 cycles after reset release.
        e0 = cyc;
        rst_n = 1'b1;
        wait_until(1, 50, at);
        check("por_reset_fall", at, e0 + 4);
        wait_until(0, 100, at);
        check("por_locked_time", at, e0 + 35);
        check("por_pix_rst_n", int'(pix_rst_n), 1);
        check("por_ready", int'(mode_req_ready), 1);
        check("por_idsel", int'(pll_idsel), exp_id[0]);

        // Table-driven requests from LOCKED.
        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].mode, t);
            check("vec_mode_cur", int'(mode_cur), vecs[i].exp_mode);
            check("vec_idsel", int'(pll_idsel), vecs[i].exp_idsel);
            check("vec_fbdsel", int'(pll_fbdsel), vecs[i].exp_fbdsel);
            check("vec_odsel", int'(pll_odsel), vecs[i].exp_odsel);
            check("vec_req_err", int'(req_err), vecs[i].exp_err);
            check("vec_locked", int'(locked), vecs[i].exp_locked);
            check("vec_pll_reset", int'(pll_reset), 1 - vecs[i].exp_locked);
            if (vecs[i].exp_err != 0) begin
                step(1);
                check("vec_req_err_pulse", int'(req_err), 0);
            end else begin
                check("vec_ready_low", int'(mode_req_ready), 0);
                wait_until(0, 100, at);
                check("vec_relock_time", at, t + 35);
                check("vec_pix_rst_n", int'(pix_rst_n), 1);
            end
        end

        // Lock glitch of two cycles inside STABLE restarts the stability count.
        do_req(1, t);
        lpt = t + 24;
        step(lpt + 6 - cyc);
        force_low = 1'b1;
        step(2);
        force_low = 1'b0;
        wait_until(0, 60, at);
        check("glitch_locked_time", at, lpt + 19);
        check("glitch_loss", int'(lock_loss_cnt), 0);

        // Lock never comes: two timeouts then FAIL; a new request recovers.
        lock_delay = 1000000;
        do_req(0, t);
        wait_until(1, 20, at);
        check("to_reset_fall", at, t + 4);
        wait_until(3, 200, at);
        check("to_retry_rst", at, t + 104);
        wait_until(2, 300, at);
        check("to_fail_time", at, t + 208);
        check("fail_pll_reset", int'(pll_reset), 1);
        check("fail_pix_rst_n", int'(pix_rst_n), 0);
        check("fail_ready", int'(mode_req_ready), 1);
        step(20);
        check("fail_reset_held", int'(pll_reset), 1);
        check("fail_held", int'(fail), 1);
        lock_delay = 20;
        do_req(1, t);
        check("fail_cleared", int'(fail), 0);
        check("fail_req_mode", int'(mode_cur), 1);
        wait_until(0, 100, at);
        check("fail_relock_time", at, t + 35);

        // 300 lock drops in LOCKED, counter saturates at 255.
        lock_delay = 2;
        for (int k = 0; k < 300; k++) begin
            p0 = cyc;
            force_low = 1'b1;
            wait_until(3, 10, x);
            check("drop_to_rst", x, p0 + 3);
            step(1);
            force_low = 1'b0;
            check("loss_cnt", int'(lock_loss_cnt), (k + 1 > 255) ? 255 : k + 1);
            wait_until(0, 60, at);
            check("drop_relock", at, x + 17);
        end
        check("drop_mode_kept", int'(mode_cur), 1);

        // Randomized requests against an outcome-level model.
        exp_mode = 1;
        exp_fail = 0;
        for (int it = 0; it < 16; it++) begin
            m = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 5));
            d = (r <= 2) ? int'($urandom_range(1, 60)) : (r == 3) ? 97 : (r == 4) ? 98
                : int'($urandom_range(99, 140));
            lock_delay = d;
            do_req(m, t);
            if (m < 3) begin
                exp_mode = m;
                check("rnd_mode_cur", int'(mode_cur), m);
                check("rnd_idsel", int'(pll_idsel), exp_id[m]);
                check("rnd_odsel", int'(pll_odsel), exp_od[m]);
                if (d <= 97) begin
                    wait_until(0, 300, at);
                    check("rnd_lock_time", at, t + 15 + d);
                    exp_fail = 0;
                end else begin
                    wait_until(2, 300, at);
                    check("rnd_fail_time", at, t + 208);
                    exp_fail = 1;
                end
            end else begin
                check("rnd_req_err", int'(req_err), 1);
                check("rnd_err_mode", int'(mode_cur), exp_mode);
                check("rnd_err_locked", int'(locked), 1 - exp_fail);
                check("rnd_err_fail", int'(fail), exp_fail);
                step(1);
            end
        end
        check("rnd_loss_sat", int'(lock_loss_cnt), 255);

        // Asynchronous reset in the middle of WAIT_LOCK.
        lock_delay = 100000;
        do_req(2, t);
        wait_until(1, 20, at);
        check("async_wait_entry", at, t + 4);
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
